// File: rtl/dmg_timer_pkg.sv
// Constants shared by the divider and the timer: divider tap positions,
// the DIV byte position and the FF04 register offset.
package dmg_timer_pkg;

  localparam int TAP_262144 = 1;
  localparam int TAP_65536  = 3;
  localparam int TAP_16384  = 5;
  localparam int TAP_4096   = 7;
  localparam int TAP_512    = 10;

  localparam int DIV_LSB = 6;

  localparam logic [1:0] FF04_OFFSET = 2'b00;

endpackage

// File: rtl/bus_tri8.sv
// 8-bit tri-state driver onto the shared CPU data bus; floats when not enabled.
module bus_tri8 (
  input  logic       i_en,
  input  logic [7:0] i_data,
  inout  tri   [7:0] io_bus
);

  assign io_bus = i_en ? i_data : 8'bzzzz_zzzz;

endmodule

// File: rtl/div_counter.sv
// Free-running system divider behind FF04 (DIV): supplies the timer and APU taps
// and serves CPU reads/writes of the upper byte.
module div_counter
  import dmg_timer_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic        boga1mhz,
  input  logic        nreset2,
  input  logic [15:0] a,
  inout  tri   [7:0]  d,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic        ff04_ff07,
  output logic        _262144hz,
  output logic        _65536hz,
  output logic        _16384hz,
  output logic        nff04_d1,
  output logic        _512hz,
  output logic [7:0]  div_q
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic             w_div_sel;
  logic             w_div_wr;
  logic             w_div_rd;
  logic             w_unused_a;

  assign w_div_sel  = ff04_ff07 && (a[1:0] == FF04_OFFSET);
  assign w_div_wr   = w_div_sel && cpu_wr;
  assign w_div_rd   = w_div_sel && cpu_rd;
  assign w_unused_a = ^a[15:2];

  // Divider chain: any write to FF04 clears it, otherwise it counts every cycle.
  always_ff @(posedge boga1mhz or negedge nreset2) begin
    if (!nreset2) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_div_wr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Taps come straight off the flops so a clear-induced fall reaches the timer.
  assign _262144hz = r_cnt[TAP_262144];
  assign _65536hz  = r_cnt[TAP_65536];
  assign _16384hz  = r_cnt[TAP_16384];
  assign nff04_d1  = ~r_cnt[TAP_4096];
  assign _512hz    = r_cnt[TAP_512];
  assign div_q     = r_cnt[DIV_LSB +: 8];

  bus_tri8 u_bus_tri8 (
    .i_en   (w_div_rd),
    .i_data (div_q),
    .io_bus (d)
  );

endmodule

// File: tb/tb_div_counter.sv
// Directed self-checking bench for div_counter; the data bus carries a pull-up so
// a floating bus reads back as 8'hFF.
module tb_div_counter;

  logic        clk;
  logic        nreset2;
  logic [15:0] a;
  tri   [7:0]  d;
  logic        cpu_wr;
  logic        cpu_rd;
  logic        ff04_ff07;
  logic        _262144hz;
  logic        _65536hz;
  logic        _16384hz;
  logic        nff04_d1;
  logic        _512hz;
  logic [7:0]  div_q;

  int n_checks;
  int n_fail;

  div_counter #(.CNT_W(14)) dut (
    .boga1mhz  (clk),
    .nreset2   (nreset2),
    .a         (a),
    .d         (d),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .ff04_ff07 (ff04_ff07),
    ._262144hz (_262144hz),
    ._65536hz  (_65536hz),
    ._16384hz  (_16384hz),
    .nff04_d1  (nff04_d1),
    ._512hz    (_512hz),
    .div_q     (div_q)
  );

  for (genvar gi = 0; gi < 8; gi++) begin : g_pull
    pullup pu_d (d[gi]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse reset between clock edges; afterwards the count equals edges since release.
  task automatic do_reset();
    @(negedge clk);
    nreset2 = 1'b0;
    edges(2);
    nreset2 = 1'b1;
  endtask

  task automatic test_reset();
    nreset2 = 1'b0;
    edges(10);
    n_checks++; if (_262144hz !== 1'b0) begin n_fail++; $display("FAIL rst_262144 got %b want 0", _262144hz); end
    n_checks++; if (_65536hz !== 1'b0) begin n_fail++; $display("FAIL rst_65536 got %b want 0", _65536hz); end
    n_checks++; if (_16384hz !== 1'b0) begin n_fail++; $display("FAIL rst_16384 got %b want 0", _16384hz); end
    n_checks++; if (_512hz !== 1'b0) begin n_fail++; $display("FAIL rst_512 got %b want 0", _512hz); end
    n_checks++; if (nff04_d1 !== 1'b1) begin n_fail++; $display("FAIL rst_nff04 got %b want 1", nff04_d1); end
    n_checks++; if (div_q !== 8'h00) begin n_fail++; $display("FAIL rst_divq got %h want 00", div_q); end
    n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL rst_bus got %h want floating", d); end
    nreset2 = 1'b1;
    edges(2);
    n_checks++; if (_262144hz !== 1'b1) begin n_fail++; $display("FAIL rst_cnt2 got %b want 1", _262144hz); end
    edges(61);
    n_checks++; if (div_q !== 8'h00) begin n_fail++; $display("FAIL rst_edge63 got %h want 00", div_q); end
    edges(1);
    n_checks++; if (div_q !== 8'h01) begin n_fail++; $display("FAIL rst_edge64 got %h want 01", div_q); end
    n_checks++; if (nff04_d1 !== 1'b1) begin n_fail++; $display("FAIL rst_nff04_64 got %b want 1", nff04_d1); end
  endtask

  task automatic test_tap_periods();
    int per  [5] = '{4, 16, 64, 256, 2048};
    int rexp [5] = '{1024, 256, 64, 16, 2};
    int hi   [5];
    int rise [5];
    int last [5];
    int bad  [5];
    logic [4:0] prev;
    logic [4:0] cur;
    do_reset();
    for (int j = 0; j < 5; j++) begin hi[j] = 0; rise[j] = 0; last[j] = -1; bad[j] = 0; end
    prev = {_512hz, nff04_d1, _16384hz, _65536hz, _262144hz};
    for (int k = 1; k <= 4096; k++) begin
      edges(1);
      cur = {_512hz, nff04_d1, _16384hz, _65536hz, _262144hz};
      for (int j = 0; j < 5; j++) begin
        if (cur[j]) hi[j]++;
        if (cur[j] && !prev[j]) begin
          if (last[j] >= 0 && (k - last[j]) != per[j]) bad[j]++;
          last[j] = k;
          rise[j]++;
        end
      end
      prev = cur;
    end
    for (int j = 0; j < 5; j++) begin
      n_checks++; if (rise[j] !== rexp[j]) begin n_fail++; $display("FAIL tap%0d_rises got %0d want %0d", j, rise[j], rexp[j]); end
      n_checks++; if (hi[j] !== 2048) begin n_fail++; $display("FAIL tap%0d_duty got %0d want 2048", j, hi[j]); end
      n_checks++; if (bad[j] !== 0) begin n_fail++; $display("FAIL tap%0d_period got %0d bad want 0", j, bad[j]); end
    end
    n_checks++; if (div_q !== 8'h40) begin n_fail++; $display("FAIL tap_divq got %h want 40", div_q); end
  endtask

  task automatic test_read();
    do_reset();
    edges(16'h1ABC);
    a = 16'hFF04; ff04_ff07 = 1'b1; cpu_rd = 1'b1;
    #1;
    n_checks++; if (d !== 8'h6A) begin n_fail++; $display("FAIL read_d got %h want 6A", d); end
    n_checks++; if (div_q !== 8'h6A) begin n_fail++; $display("FAIL read_divq got %h want 6A", div_q); end
    cpu_rd = 1'b0;
    #1;
    n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL read_release got %h want floating", d); end
    a = 16'hFF05; cpu_rd = 1'b1;
    #1;
    n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL read_ff05 got %h want floating", d); end
    cpu_rd = 1'b0; ff04_ff07 = 1'b0;
  endtask

  task automatic test_write_glitch();
    do_reset();
    edges(16'h0020);
    n_checks++; if (_16384hz !== 1'b1) begin n_fail++; $display("FAIL wr_pre got %b want 1", _16384hz); end
    a = 16'hFF04; ff04_ff07 = 1'b1; cpu_wr = 1'b1;
    edges(1);
    cpu_wr = 1'b0; ff04_ff07 = 1'b0;
    n_checks++; if (_16384hz !== 1'b0) begin n_fail++; $display("FAIL wr_glitch got %b want 0", _16384hz); end
    n_checks++; if (div_q !== 8'h00) begin n_fail++; $display("FAIL wr_divq got %h want 00", div_q); end
    edges(2);
    n_checks++; if (_262144hz !== 1'b1) begin n_fail++; $display("FAIL wr_resume got %b want 1", _262144hz); end
  endtask

  task automatic test_held_write();
    do_reset();
    edges(14);
    n_checks++; if ({_65536hz, _262144hz} !== 2'b11) begin n_fail++; $display("FAIL hold_pre got %b want 11", {_65536hz, _262144hz}); end
    a = 16'hFF04; ff04_ff07 = 1'b1; cpu_wr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      edges(1);
      n_checks++; if ({_65536hz, _262144hz} !== 2'b00) begin n_fail++; $display("FAIL hold_cyc%0d got %b want 00", k, {_65536hz, _262144hz}); end
    end
    cpu_wr = 1'b0; ff04_ff07 = 1'b0;
    edges(1);
    n_checks++; if (_262144hz !== 1'b0) begin n_fail++; $display("FAIL hold_rel1 got %b want 0", _262144hz); end
    edges(1);
    n_checks++; if (_262144hz !== 1'b1) begin n_fail++; $display("FAIL hold_rel2 got %b want 1", _262144hz); end
    edges(61);
    n_checks++; if (div_q !== 8'h00) begin n_fail++; $display("FAIL hold_e63 got %h want 00", div_q); end
    edges(1);
    n_checks++; if (div_q !== 8'h01) begin n_fail++; $display("FAIL hold_e64 got %h want 01", div_q); end
  endtask

  task automatic test_wrap_async();
    do_reset();
    edges(16383);
    n_checks++; if ({_512hz, nff04_d1, _16384hz, _65536hz, _262144hz} !== 5'b10111) begin n_fail++; $display("FAIL wrap_pre got %b want 10111", {_512hz, nff04_d1, _16384hz, _65536hz, _262144hz}); end
    n_checks++; if (div_q !== 8'hFF) begin n_fail++; $display("FAIL wrap_pre_divq got %h want FF", div_q); end
    edges(1);
    n_checks++; if ({_512hz, nff04_d1, _16384hz, _65536hz, _262144hz} !== 5'b01000) begin n_fail++; $display("FAIL wrap_taps got %b want 01000", {_512hz, nff04_d1, _16384hz, _65536hz, _262144hz}); end
    n_checks++; if (div_q !== 8'h00) begin n_fail++; $display("FAIL wrap_divq got %h want 00", div_q); end
    edges(16'h0123);
    n_checks++; if ({_512hz, nff04_d1, _16384hz, _65536hz, _262144hz} !== 5'b01101) begin n_fail++; $display("FAIL async_pre got %b want 01101", {_512hz, nff04_d1, _16384hz, _65536hz, _262144hz}); end
    n_checks++; if (div_q !== 8'h04) begin n_fail++; $display("FAIL async_pre_divq got %h want 04", div_q); end
    #2;
    nreset2 = 1'b0;
    #1;
    n_checks++; if ({_512hz, nff04_d1, _16384hz, _65536hz, _262144hz} !== 5'b01000) begin n_fail++; $display("FAIL async_taps got %b want 01000", {_512hz, nff04_d1, _16384hz, _65536hz, _262144hz}); end
    n_checks++; if (div_q !== 8'h00) begin n_fail++; $display("FAIL async_divq got %h want 00", div_q); end
    edges(2);
    nreset2 = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    nreset2   = 1'b0;
    a         = 16'h0000;
    cpu_wr    = 1'b0;
    cpu_rd    = 1'b0;
    ff04_ff07 = 1'b0;
    test_reset();
    test_tap_periods();
    test_read();
    test_write_glitch();
    test_held_write();
    test_wrap_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
